// File: rtl/mont_alu.sv
// mont_alu: word-serial Montgomery multiplier with modular add, subtract and copy.
// An operation starts on the first clock edge where rst is low. The result
// appears on mul with done=1 and is held there until rst is asserted again.
module mont_alu #(
    parameter int N = 512,
    parameter int word_size = 32,
    parameter logic [N-1:0] p = 512'h65B48E8F740F89BFFC8AB0D15E3E4C4AB42D083AEDC88C425AFBFCC69322C9CDA7AAC6C567F35507516730CC1F0B4F25C2721BF457ACA8351B81B90533C6C87B,
    // Only the low word_size bits are used: (-p)^-1 mod 2^word_size.
    parameter logic [N-1:0] p_inv = 512'h632E294D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   op,
    output logic [N-1:0] mul,
    output logic         done
);

    localparam int DIGITS = N / word_size;
    // The pre-shift sum s + A*b_i + m*p stays below 2^(N+word_size+1).
    localparam int SW = N + word_size + 2;
    localparam int CW = $clog2(DIGITS) + 1;

    typedef enum logic [1:0] {IDLE, ITER, FINAL, DONE} state_t;

    state_t                state;
    logic [N-1:0]          a_q;
    logic [N-1:0]          b_q;     // shifted right one digit per ITER edge
    logic [1:0]            op_q;
    logic [SW-1:0]         s_q;
    logic [CW-1:0]         i_q;

    logic [SW-1:0]         s_acc;
    logic [word_size-1:0]  m_dig;
    logic [SW-1:0]         s_red;
    logic [SW-1:0]         s_next;
    logic [N-1:0]          result;

    // Returns x - p when x >= p, else x; valid for inputs below 2p.
    function automatic logic [N-1:0] cond_sub(input logic [N:0] x);
        logic [N:0] d;
        d = x - {1'b0, p};
        if (x >= {1'b0, p})
            return d[N-1:0];
        else
            return x[N-1:0];
    endfunction

    // (x - y) mod p for x, y in [0, p-1]; N-bit wraparound absorbs the borrow.
    function automatic logic [N-1:0] mod_sub(input logic [N-1:0] x, input logic [N-1:0] y);
        if (x >= y)
            return x - y;
        else
            return x - y + p;
    endfunction

    // One Montgomery digit step: accumulate A*b_i, add m*p to clear the low word, shift out.
    always_comb begin
        s_acc  = s_q + SW'(a_q) * SW'(b_q[word_size-1:0]);
        m_dig  = s_acc[word_size-1:0] * p_inv[word_size-1:0];
        s_red  = s_acc + SW'(m_dig) * SW'(p);
        s_next = s_red >> word_size;
    end

    // Final-edge result selection; the Montgomery accumulator ends below 2p.
    always_comb begin
        result = a_q;
        case (op_q)
            2'b00:   result = cond_sub(s_q[N:0]);
            2'b01:   result = cond_sub({1'b0, a_q} + {1'b0, b_q});
            2'b10:   result = mod_sub(a_q, b_q);
            default: result = a_q;
        endcase
    end

    // Control FSM with captured operands and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            mul   <= '0;
            i_q   <= '0;
            s_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    a_q   <= A;
                    b_q   <= B;
                    op_q  <= op;
                    s_q   <= '0;
                    i_q   <= '0;
                    state <= (op == 2'b00) ? ITER : FINAL;
                end
                ITER: begin
                    s_q <= s_next;
                    b_q <= b_q >> word_size;
                    i_q <= i_q + CW'(1);
                    if (i_q == CW'(DIGITS - 1))
                        state <= FINAL;
                end
                FINAL: begin
                    mul   <= result;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_alu.sv
// tb_mont_alu: randomized and directed bench for mont_alu at N=64, word_size=32.
// The driver queues the expected result of each operation; a negedge monitor
// pops and compares when done rises, then watches mul stay put while done holds.
module tb_mont_alu;

    localparam int N = 64;
    localparam int W = 32;
    localparam logic [63:0] P = 64'hFFFFFFFF00000001;
    localparam int MUL_LAT = N / W + 2;
    localparam int N_RAND = 400;

    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic [63:0] mul;
    logic        done;

    mont_alu #(
        .N(N),
        .word_size(W),
        .p(P),
        .p_inv(64'h00000000FFFFFFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .A(a),
        .B(b),
        .op(op),
        .mul(mul),
        .done(done)
    );

    typedef struct {
        logic [63:0] exp;
        int          start;
        int          lat;
    } txn_t;

    txn_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle_cnt = 0;
    logic        done_prev = 1'b0;
    logic [63:0] cur_exp = '0;
    logic [63:0] rinv;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_cnt = cycle_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cycle_cnt);
        end
    endtask

    // ---------------- reference model: plain modular arithmetic ----------------
    function automatic logic [63:0] mulmod(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] t;
        t = {64'd0, x} * {64'd0, y};
        t = t % {64'd0, P};
        return t[63:0];
    endfunction

    function automatic logic [63:0] powmod(input logic [63:0] base, input logic [63:0] e);
        logic [63:0] r;
        logic [63:0] bb;
        r  = 64'd1;
        bb = base;
        for (int k = 0; k < 64; k++) begin
            if (e[k]) r = mulmod(r, bb);
            bb = mulmod(bb, bb);
        end
        return r;
    endfunction

    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [64:0] t;
        case (o)
            2'b00:   return mulmod(mulmod(x, y), rinv);
            2'b01: begin
                t = ({1'b0, x} + {1'b0, y}) % {1'b0, P};
                return t[63:0];
            end
            2'b10: begin
                t = ({1'b0, x} + {1'b0, P} - {1'b0, y}) % {1'b0, P};
                return t[63:0];
            end
            default: return x;
        endcase
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 9))
            0:       v = 64'd0;
            1:       v = P - 64'd1;
            2:       v = 64'd1;
            default: begin
                v = {$urandom, $urandom};
                while (v >= P) v = {$urandom, $urandom};
            end
        endcase
        return v;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        txn_t t;
        if (done) begin
            if (!done_prev) begin
                if (sb.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL spurious_done actual=done_high required=no_pending_op at cycle %0d", cycle_cnt);
                end else begin
                    t = sb.pop_front();
                    chk("result", mul, t.exp);
                    chk("latency", 64'(cycle_cnt - t.start), 64'(t.lat));
                    cur_exp = t.exp;
                end
            end else begin
                chk("hold_mul", mul, cur_exp);
            end
        end
        done_prev = done;
    end

    // ---------------- driver ----------------
    // Entered at a negedge; pulses rst for one edge, launches, waits for done, holds.
    task automatic run_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] exp, input int hold);
        txn_t t;
        bit   seen;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_mul", mul, 64'd0);
        rst = 1'b0;
        a   = x;
        b   = y;
        op  = o;
        t.exp   = exp;
        t.start = cycle_cnt;
        t.lat   = (o == 2'b00) ? MUL_LAT : 2;
        sb.push_back(t);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL done_timeout actual=no_done required=done op=%0d", o);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        for (int h = 0; h < hold; h++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            op = 2'($urandom);
            @(negedge clk);
            chk("hold_done", {63'd0, done}, 64'd1);
        end
    endtask

    initial begin
        logic [127:0] rmod;
        logic [63:0]  x;
        logic [63:0]  y;
        logic [1:0]   o;
        rst = 1'b1;
        a   = '0;
        b   = '0;
        op  = '0;
        rmod = (128'd1 << 64) % {64'd0, P};
        rinv = powmod(rmod[63:0], P - 64'd2);

        @(negedge clk);
        // Directed cases
        run_op(2'b00, 64'h00000000FFFFFFFF, 64'd5, 64'd5, 20);
        run_op(2'b01, 64'hFFFFFFFF00000000, 64'd2, 64'd1, 0);
        run_op(2'b01, 64'd3, 64'd4, 64'd7, 0);
        run_op(2'b10, 64'd1, 64'd2, 64'hFFFFFFFF00000000, 0);
        run_op(2'b10, 64'd9, 64'd9, 64'd0, 0);
        run_op(2'b00, 64'd0, 64'hFFFFFFFF00000000, 64'd0, 0);
        run_op(2'b11, 64'd123, 64'hDEADBEEF, 64'd123, 20);

        // Abort a multiply on its second edge, then check a clean add follows
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        a   = 64'h123456789ABCDEF0;
        b   = 64'h0FEDCBA987654321;
        op  = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_mul", mul, 64'd0);
        run_op(2'b01, 64'd1, 64'd1, 64'd2, 0);

        // Randomized operations against the model
        for (int k = 0; k < 4 * N_RAND; k++) begin
            o = 2'(k % 4);
            x = rand_operand();
            y = rand_operand();
            run_op(o, x, y, model(o, x, y), ($urandom_range(0, 19) == 0) ? 20 : 0);
        end

        @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
